gate_selftest_ctrl: RTL and testbench

GATE_SELFTEST_CTRL -- requirements
Module: gate_selftest_ctrl

---
 rtl/gate_selftest_ctrl.sv | 146 ++++++++++++++
 tb/tb_gate_selftest_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/gate_selftest_ctrl.sv
// Truth-table self-test sequencer for a 2-input gate: applies each vector,
// waits for it to settle, compares gate_out with the expected table and logs mismatches.
module gate_selftest_ctrl #(
    parameter int unsigned SETTLE    = 2,
    parameter logic [3:0]  EXP_TABLE = 4'b0111
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic       gate_out,
    output logic       gate_a,
    output logic       gate_b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] fail_count,
    output logic [3:0] fail_mask
);

    // state     | meaning
    // ST_IDLE   | waiting for start; gate inputs parked at 0
    // ST_APPLY  | vector vec on the gate inputs, settle timer loaded
    // ST_SETTLE | timer counting down to terminal count with inputs stable
    // ST_CHECK  | gate_out compared against EXP_TABLE[vec]
    // ST_DONE   | one-cycle done pulse, result latched into pass
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } state_t;

    // Timer is loaded with SETTLE-1 so the SETTLE state spans exactly SETTLE cycles.
    localparam logic [3:0] SETTLE_LOAD = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);

    state_t     state, state_nxt;
    logic [1:0] vec, vec_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       gate_a_nxt, gate_b_nxt, pass_nxt;
    logic [2:0] fail_count_nxt;
    logic [3:0] fail_mask_nxt;
    logic       mismatch;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            vec        <= 2'd0;
            cnt        <= 4'd0;
            gate_a     <= 1'b0;
            gate_b     <= 1'b0;
            pass       <= 1'b0;
            fail_count <= 3'd0;
            fail_mask  <= 4'd0;
        end else begin
            state      <= state_nxt;
            vec        <= vec_nxt;
            cnt        <= cnt_nxt;
            gate_a     <= gate_a_nxt;
            gate_b     <= gate_b_nxt;
            pass       <= pass_nxt;
            fail_count <= fail_count_nxt;
            fail_mask  <= fail_mask_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        vec_nxt        = vec;
        cnt_nxt        = cnt;
        gate_a_nxt     = gate_a;
        gate_b_nxt     = gate_b;
        pass_nxt       = pass;
        fail_count_nxt = fail_count;
        fail_mask_nxt  = fail_mask;
        busy           = 1'b0;
        done           = 1'b0;
        // Case inequality so an X/Z from the gate counts as a failure.
        mismatch       = (gate_out !== EXP_TABLE[vec]);

        case (state)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_nxt      = ST_APPLY;
                    vec_nxt        = 2'd0;
                    fail_count_nxt = 3'd0;
                    fail_mask_nxt  = 4'd0;
                    pass_nxt       = 1'b0;
                    gate_a_nxt     = 1'b0;
                    gate_b_nxt     = 1'b0;
                end
            end
            ST_APPLY: begin
                busy      = 1'b1;
                cnt_nxt   = SETTLE_LOAD;
                state_nxt = (SETTLE == 0) ? ST_CHECK : ST_SETTLE;
            end
            ST_SETTLE: begin
                busy = 1'b1;
                if (cnt == 4'd0) begin
                    state_nxt = ST_CHECK;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            ST_CHECK: begin
                busy = 1'b1;
                if (mismatch) begin
                    fail_mask_nxt = fail_mask | (4'b0001 << vec);
                    if (fail_count < 3'd4) begin
                        fail_count_nxt = fail_count + 3'd1;
                    end
                end
                if (vec == 2'd3) begin
                    state_nxt  = ST_DONE;
                    gate_a_nxt = 1'b0;
                    gate_b_nxt = 1'b0;
                    pass_nxt   = (fail_count_nxt == 3'd0);
                end else begin
                    state_nxt                = ST_APPLY;
                    vec_nxt                  = vec + 2'd1;
                    {gate_a_nxt, gate_b_nxt} = vec + 2'd1;
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Abort discards whatever this cycle would have recorded, keeps partial results.
        if (abort && busy) begin
            state_nxt      = ST_IDLE;
            vec_nxt        = vec;
            cnt_nxt        = cnt;
            gate_a_nxt     = 1'b0;
            gate_b_nxt     = 1'b0;
            pass_nxt       = 1'b0;
            fail_count_nxt = fail_count;
            fail_mask_nxt  = fail_mask;
        end
    end

endmodule

// File: tb/tb_gate_selftest_ctrl.sv
// Randomized self-checking bench for gate_selftest_ctrl: two instances (default timing,
// and zero-settle AND table) driven by a truth-table gate model and checked against a sweep model.
module tb_gate_selftest_ctrl;

    logic       clk = 1'b0;
    logic       reset, abort, start1, start2;
    logic [3:0] tt1, tt2;
    logic       gate_out1, gate_out2;
    logic       gate_a1, gate_b1, busy1, done1, pass1;
    logic       gate_a2, gate_b2, busy2, done2, pass2;
    logic [2:0] fail_count1, fail_count2;
    logic [3:0] fail_mask1, fail_mask2;
    logic       sel;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    assign gate_out1 = tt1[{gate_a1, gate_b1}];
    assign gate_out2 = tt2[{gate_a2, gate_b2}];

    gate_selftest_ctrl dut1 (
        .clk(clk), .reset(reset), .start(start1), .abort(abort), .gate_out(gate_out1),
        .gate_a(gate_a1), .gate_b(gate_b1), .busy(busy1), .done(done1), .pass(pass1),
        .fail_count(fail_count1), .fail_mask(fail_mask1)
    );

    gate_selftest_ctrl #(.SETTLE(0), .EXP_TABLE(4'b1000)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .abort(abort), .gate_out(gate_out2),
        .gate_a(gate_a2), .gate_b(gate_b2), .busy(busy2), .done(done2), .pass(pass2),
        .fail_count(fail_count2), .fail_mask(fail_mask2)
    );

    wire       busy_s  = sel ? busy2 : busy1;
    wire       done_s  = sel ? done2 : done1;
    wire       pass_s  = sel ? pass2 : pass1;
    wire [1:0] gates_s = sel ? {gate_a2, gate_b2} : {gate_a1, gate_b1};
    wire [2:0] cnt_s   = sel ? fail_count2 : fail_count1;
    wire [3:0] mask_s  = sel ? fail_mask2 : fail_mask1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_start(input logic v);
        if (sel) start2 = v;
        else     start1 = v;
    endtask

    task automatic chk_idle_clear(input string tag);
        chk({tag, "_busy"}, busy_s, 0);
        chk({tag, "_done"}, done_s, 0);
        chk({tag, "_pass"}, pass_s, 0);
        chk({tag, "_gates"}, gates_s, 0);
        chk({tag, "_cnt"}, cnt_s, 0);
        chk({tag, "_mask"}, mask_s, 0);
    endtask

    // One sweep on instance d with gate truth table tt; optional abort/reset in cycle
    // abort_at/reset_at (1-based after the start-sampling edge), optional start in DONE.
    task automatic sweep(input logic d, input logic [3:0] tt, input int abort_at,
                         input int reset_at, input bit start_in_done);
        int         per;
        int         total;
        logic [3:0] expt;
        logic [3:0] full;
        logic [3:0] part;
        logic       pass_exp;
        sel   = d;
        per   = d ? 2 : 4;
        total = 4 * per;
        expt  = d ? 4'b1000 : 4'b0111;
        full  = tt ^ expt;
        if (d) tt2 = tt;
        else   tt1 = tt;
        set_start(1'b1);
        tick();
        set_start(1'b0);
        for (int c = 1; c <= total; c++) begin
            chk("busy_run", busy_s, 1);
            chk("done_run", done_s, 0);
            chk("vector", gates_s, (c - 1) / per);
            if ($urandom_range(0, 3) == 0) set_start(1'b1);
            if (c == abort_at) abort = 1'b1;
            if (c == reset_at) reset = 1'b1;
            tick();
            set_start(1'b0);
            if (c == abort_at) begin
                abort = 1'b0;
                part  = 4'd0;
                for (int v = 0; v < 4; v++)
                    if (per * (v + 1) < c) part[v] = full[v];
                chk("abort_busy", busy_s, 0);
                chk("abort_done", done_s, 0);
                chk("abort_pass", pass_s, 0);
                chk("abort_gates", gates_s, 0);
                chk("abort_mask", mask_s, part);
                chk("abort_cnt", cnt_s, $countones(part));
                for (int k = 0; k < 3; k++) begin
                    tick();
                    chk("abort_nodone", done_s, 0);
                    chk("abort_stay", busy_s, 0);
                end
                return;
            end
            if (c == reset_at) begin
                reset = 1'b0;
                chk_idle_clear("reset_mid");
                tick();
                chk("reset_nodone", done_s, 0);
                return;
            end
        end
        pass_exp = (full == 4'd0);
        chk("done_pulse", done_s, 1);
        chk("done_busy", busy_s, 0);
        chk("done_gates", gates_s, 0);
        chk("done_pass", pass_s, pass_exp);
        chk("done_cnt", cnt_s, $countones(full));
        chk("done_mask", mask_s, full);
        if (start_in_done) set_start(1'b1);
        tick();
        set_start(1'b0);
        chk("done_once", done_s, 0);
        chk("post_busy", busy_s, 0);
        tick();
        chk("no_restart", busy_s, 0);
        chk("pass_hold", pass_s, pass_exp);
        chk("mask_hold", mask_s, full);
    endtask

    initial begin
        reset  = 1'b1;
        abort  = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
        tt1    = 4'b0111;
        tt2    = 4'b1000;
        sel    = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk_idle_clear("rst1");
        sel = 1'b1;
        chk_idle_clear("rst2");

        sweep(1'b0, 4'b0111, 0, 0, 1'b0);   // ideal NAND
        sweep(1'b0, 4'b1111, 0, 0, 1'b1);   // stuck-at-1
        sweep(1'b0, 4'b0000, 0, 0, 1'b0);   // stuck-at-0

        sel    = 1'b0;
        start1 = 1'b1;
        abort  = 1'b1;
        tick();
        start1 = 1'b0;
        abort  = 1'b0;
        chk("abort_wins", busy_s, 0);
        tick();
        chk("abort_wins2", busy_s, 0);

        sweep(1'b0, 4'b0000, 10, 0, 1'b0);  // abort in vector 2 settle
        sweep(1'b0, 4'b0111, 0, 6, 1'b0);   // reset during vector 1
        sweep(1'b0, 4'b0111, 0, 0, 1'b0);   // clean sweep after reset
        sweep(1'b1, 4'b1000, 0, 0, 1'b0);   // AND, zero settle
        sweep(1'b1, 4'b0111, 0, 0, 1'b0);   // NAND against AND table
        sweep(1'b1, 4'b0000, 8, 0, 1'b0);   // abort in last check: not recorded

        for (int i = 0; i < 40; i++) begin
            logic d;
            int   tot;
            int   ab;
            int   rs;
            d   = 1'($urandom_range(0, 1));
            tot = d ? 8 : 16;
            ab  = 0;
            rs  = 0;
            case ($urandom_range(0, 3))
                0:       ab = $urandom_range(1, tot);
                1:       rs = $urandom_range(1, tot);
                default: ;
            endcase
            sweep(d, 4'($urandom_range(0, 15)), ab, rs, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
